// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared tile codes, player FSM states and default key codes
package game_pkg;

   localparam logic [3:0] TILE_FLOOR = 4'd0;
   localparam logic [3:0] TILE_WALL  = 4'd1;
   localparam logic [3:0] TILE_BRICK = 4'd2;
   localparam logic [3:0] TILE_RSVD  = 4'd3;
   localparam logic [3:0] TILE_LIFE  = 4'd4;
   localparam logic [3:0] TILE_SPEED = 4'd5;

   localparam logic [7:0] KEY_UP_DEF   = 8'h52;
   localparam logic [7:0] KEY_DN_DEF   = 8'h51;
   localparam logic [7:0] KEY_LF_DEF   = 8'h50;
   localparam logic [7:0] KEY_RT_DEF   = 8'h4F;
   localparam logic [7:0] KEY_BOMB_DEF = 8'h13;

   typedef enum logic [2:0] {
      S_IDLE,
      S_QUERY,
      S_RESOLVE,
      S_RESPAWN,
      S_DEAD
   } player_state_t;

   // Walls and bricks stop movement; every other code is walkable.
   function automatic logic is_solid(input logic [3:0] code);
      return (code == TILE_WALL) || (code == TILE_BRICK);
   endfunction

   // Codes the player collects by standing on them.
   function automatic logic is_pickup(input logic [3:0] code);
      return (code == TILE_LIFE) || (code == TILE_SPEED);
   endfunction

endpackage

// File: rtl/tile_addr_calc.sv
// rtl/tile_addr_calc.sv - pixel coordinate to linear map tile address
module tile_addr_calc #(
   parameter int MAP_W   = 20,
   parameter int TILE_SH = 5
) (
   input  logic [9:0] px,
   input  logic [9:0] py,
   output logic [9:0] addr
);

   logic [9:0] col;
   logic [9:0] row;
   logic [9:0] row_base;

   // Row-major tile index, kept in 10 bits like the rest of the map logic.
   always_comb begin
      col      = px >> TILE_SH;
      row      = py >> TILE_SH;
      row_base = row * 10'(MAP_W);
      addr     = row_base + col;
   end

endmodule

// File: rtl/player_ctrl.sv
// rtl/player_ctrl.sv - per-frame player movement, collision, pickups, blasts and lives
module player_ctrl
   import game_pkg::*;
#(
   parameter int MAP_W         = 20,
   parameter int TILE_SH       = 5,
   parameter int NUM_BLAST     = 10,
   parameter int START_X       = 522,
   parameter int START_Y       = 394,
   parameter int START_LIVES   = 3,
   parameter int MAX_LIVES     = 7,
   parameter int SPEED_MAX     = 3,
   parameter int INVULN_FRAMES = 60,
   parameter int SIZE_X        = 20,
   parameter int SIZE_Y        = 27,
   parameter logic [7:0] KEY_UP   = KEY_UP_DEF,
   parameter logic [7:0] KEY_DN   = KEY_DN_DEF,
   parameter logic [7:0] KEY_LF   = KEY_LF_DEF,
   parameter logic [7:0] KEY_RT   = KEY_RT_DEF,
   parameter logic [7:0] KEY_BOMB = KEY_BOMB_DEF
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   frame_tick,
   input  logic                   enable,
   input  logic [7:0]             keycode,
   input  logic [NUM_BLAST*10-1:0] blast_addr,
   input  logic [NUM_BLAST-1:0]   blast_valid,
   output logic                   map_rd,
   output logic [9:0]             map_addr,
   input  logic [3:0]             map_data,
   output logic                   pickup_clr,
   output logic [9:0]             pickup_addr,
   output logic [9:0]             pos_x,
   output logic [9:0]             pos_y,
   output logic [2:0]             lives,
   output logic [1:0]             speed,
   output logic                   alive,
   output logic                   invuln,
   output logic                   busy,
   output logic                   bomb_drop
);

   localparam logic [9:0] START_X10 = 10'(START_X);
   localparam logic [9:0] START_Y10 = 10'(START_Y);
   localparam logic [9:0] X_LO      = 10'd32;
   localparam logic [9:0] Y_LO      = 10'd32;
   localparam logic [9:0] X_HI      = 10'(575 - SIZE_X);
   localparam logic [9:0] Y_HI      = 10'(447 - SIZE_Y);
   localparam logic [7:0] INV_LOAD  = 8'(INVULN_FRAMES);

   player_state_t    state;
   logic [2:0]       q_cnt;
   logic [9:0]       cand_x;
   logic [9:0]       cand_y;
   logic [3:0][3:0]  code_q;
   logic [7:0]       inv_cnt;
   logic [7:0]       prev_key;
   logic             bomb_pend;

   logic [9:0]       next_x;
   logic [9:0]       next_y;
   logic [9:0]       src_x;
   logic [9:0]       src_y;
   logic [3:0][9:0]  cand_addr;
   logic [3:0][9:0]  cur_addr;
   logic             tick_en;
   logic             blast_hit;
   logic             blocked;
   logic             in_bounds;
   logic             pk_hit;
   logic [1:0]       pk_idx;

   assign tick_en = frame_tick & enable;
   assign invuln  = (inv_cnt != 8'd0);

   // Candidate position from the current key; unrecognised keys mean no motion.
   always_comb begin
      next_x = pos_x;
      next_y = pos_y;
      if (keycode == KEY_RT)
         next_x = pos_x + {8'd0, speed};
      else if (keycode == KEY_LF)
         next_x = pos_x - {8'd0, speed};
      else if (keycode == KEY_DN)
         next_y = pos_y + {8'd0, speed};
      else if (keycode == KEY_UP)
         next_y = pos_y - {8'd0, speed};
   end

   // In IDLE the address units see the not-yet-latched candidate so the TL read can issue on entry.
   always_comb begin
      src_x = (state == S_IDLE) ? next_x : cand_x;
      src_y = (state == S_IDLE) ? next_y : cand_y;
   end

   // Corner index bit0 selects the right edge, bit1 the bottom edge: TL, TR, BL, BR.
   for (genvar c = 0; c < 4; c++) begin : g_corner
      localparam logic [9:0] OFF_X = ((c & 1) != 0) ? 10'(SIZE_X) : 10'd0;
      localparam logic [9:0] OFF_Y = ((c & 2) != 0) ? 10'(SIZE_Y) : 10'd0;

      tile_addr_calc #(.MAP_W(MAP_W), .TILE_SH(TILE_SH)) u_cand (
         .px   (src_x + OFF_X),
         .py   (src_y + OFF_Y),
         .addr (cand_addr[c])
      );

      tile_addr_calc #(.MAP_W(MAP_W), .TILE_SH(TILE_SH)) u_cur (
         .px   (pos_x + OFF_X),
         .py   (pos_y + OFF_Y),
         .addr (cur_addr[c])
      );
   end

   // Any current corner sitting on any active blast tile.
   always_comb begin
      blast_hit = 1'b0;
      for (int b = 0; b < NUM_BLAST; b++) begin
         for (int c = 0; c < 4; c++) begin
            if (blast_valid[b] && (blast_addr[b*10 +: 10] == cur_addr[c]))
               blast_hit = 1'b1;
         end
      end
   end

   // Movement legality from the captured corner codes and the playfield box.
   always_comb begin
      blocked = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (is_solid(code_q[c]))
            blocked = 1'b1;
      end
      in_bounds = (cand_x >= X_LO) && (cand_x <= X_HI) &&
                  (cand_y >= Y_LO) && (cand_y <= Y_HI);
   end

   // First pickup corner in TL, TR, BL, BR priority; scanning downward leaves the lowest index.
   always_comb begin
      pk_hit = 1'b0;
      pk_idx = 2'd0;
      for (int c = 3; c >= 0; c--) begin
         if (is_pickup(code_q[c])) begin
            pk_hit = 1'b1;
            pk_idx = 2'(c);
         end
      end
   end

   // Frame FSM: latch candidate, read four corners, resolve, optionally respawn or die.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= S_IDLE;
         q_cnt       <= 3'd0;
         cand_x      <= START_X10;
         cand_y      <= START_Y10;
         code_q      <= '0;
         inv_cnt     <= 8'd0;
         prev_key    <= 8'd0;
         bomb_pend   <= 1'b0;
         pos_x       <= START_X10;
         pos_y       <= START_Y10;
         lives       <= 3'(START_LIVES);
         speed       <= 2'd1;
         alive       <= 1'b1;
         busy        <= 1'b0;
         map_rd      <= 1'b0;
         map_addr    <= 10'd0;
         pickup_clr  <= 1'b0;
         pickup_addr <= 10'd0;
         bomb_drop   <= 1'b0;
      end else begin
         pickup_clr <= 1'b0;
         bomb_drop  <= 1'b0;

         if (tick_en && (state != S_DEAD) && (inv_cnt != 8'd0))
            inv_cnt <= inv_cnt - 8'd1;

         case (state)
            S_IDLE: begin
               if (tick_en && alive) begin
                  cand_x    <= next_x;
                  cand_y    <= next_y;
                  bomb_pend <= (keycode == KEY_BOMB) && (prev_key != KEY_BOMB);
                  prev_key  <= keycode;
                  map_rd    <= 1'b1;
                  map_addr  <= cand_addr[0];
                  q_cnt     <= 3'd0;
                  busy      <= 1'b1;
                  state     <= S_QUERY;
               end
            end

            S_QUERY: begin
               // Data for the read issued in the previous cycle arrives now.
               if (q_cnt != 3'd0)
                  code_q[2'(q_cnt - 3'd1)] <= map_data;
               if (q_cnt < 3'd3) begin
                  map_rd   <= 1'b1;
                  map_addr <= cand_addr[2'(q_cnt + 3'd1)];
               end else begin
                  map_rd <= 1'b0;
               end
               if (q_cnt == 3'd4) begin
                  bomb_drop <= bomb_pend;
                  state     <= S_RESOLVE;
               end
               q_cnt <= q_cnt + 3'd1;
            end

            S_RESOLVE: begin
               if (blast_hit && !invuln) begin
                  lives <= lives - 3'd1;
                  state <= S_RESPAWN;
               end else begin
                  if (!blocked && in_bounds) begin
                     pos_x <= cand_x;
                     pos_y <= cand_y;
                  end
                  if (pk_hit) begin
                     pickup_clr  <= 1'b1;
                     pickup_addr <= cand_addr[pk_idx];
                     if (code_q[pk_idx] == TILE_LIFE) begin
                        if (lives < 3'(MAX_LIVES))
                           lives <= lives + 3'd1;
                     end else begin
                        if (speed < 2'(SPEED_MAX))
                           speed <= speed + 2'd1;
                     end
                  end
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end

            S_RESPAWN: begin
               pos_x   <= START_X10;
               pos_y   <= START_Y10;
               speed   <= 2'd1;
               inv_cnt <= INV_LOAD;
               busy    <= 1'b0;
               if (lives == 3'd0) begin
                  alive <= 1'b0;
                  state <= S_DEAD;
               end else begin
                  state <= S_IDLE;
               end
            end

            S_DEAD: begin
               map_rd <= 1'b0;
               alive  <= 1'b0;
               busy   <= 1'b0;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
